chord_note_player: RTL

- Downstream consumer of the chord song reader.
- Latches a 3-voice chord (three 6-bit notes and three 6-bit durations) on each new_note pulse.
- Counts each voice's duration down in beats and presents the currently sounding note per voice to the per-voice note generators.
- Pulses note_done once when the last active voice of the chord expires.

---
 rtl/chord_note_player_if.sv | 32 +++
 rtl/chord_note_player.sv | 112 +++++++++++
 2 files changed

// File: rtl/chord_note_player_if.sv
// Chord player bus: chord load inputs from the song reader and per-voice outputs
// to the note generators.
//   play, beat, new_note       : run/pause level, beat tick, chord load strobe
//   notes_in, durations_in     : packed {voice0, voice1, voice2}, voice0 in the top slice
//   voice_note                 : sounding note per voice, same packing
//   voice_active, voice_start  : bit2=voice0 .. bit0=voice2
//   note_done                  : one-cycle pulse when a chord has fully expired
interface chord_note_player_if #(
  parameter int unsigned NOTE_WIDTH     = 6,
  parameter int unsigned DURATION_WIDTH = 6,
  parameter int unsigned VOICES         = 3
);
  logic                             play;
  logic                             beat;
  logic                             new_note;
  logic [VOICES*NOTE_WIDTH-1:0]     notes_in;
  logic [VOICES*DURATION_WIDTH-1:0] durations_in;
  logic [VOICES*NOTE_WIDTH-1:0]     voice_note;
  logic [VOICES-1:0]                voice_active;
  logic [VOICES-1:0]                voice_start;
  logic                             note_done;

  modport master (
    output play, beat, new_note, notes_in, durations_in,
    input  voice_note, voice_active, voice_start, note_done
  );

  modport slave (
    input  play, beat, new_note, notes_in, durations_in,
    output voice_note, voice_active, voice_start, note_done
  );
endinterface

// File: rtl/chord_note_player.sv
// Chord note player: latches a 3-voice chord on new_note, counts each voice's
// duration down on beat ticks and presents the sounding note per voice.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : chord_note_player_if slave (load inputs, per-voice outputs, note_done)
module chord_note_player #(
  parameter int unsigned NOTE_WIDTH     = 6,
  parameter int unsigned DURATION_WIDTH = 6,
  parameter int unsigned VOICES         = 3
) (
  input logic                clk,
  input logic                reset,
  chord_note_player_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StPlaying, StDone} state_e;

  state_e state_q, state_d;

  // Voice-indexed storage: index 0 is voice0 (top slice of the packed buses).
  logic [NOTE_WIDTH-1:0]     note_q      [VOICES];
  logic [NOTE_WIDTH-1:0]     note_d      [VOICES];
  logic [DURATION_WIDTH-1:0] remaining_q [VOICES];
  logic [DURATION_WIDTH-1:0] remaining_d [VOICES];
  logic [VOICES-1:0]         active_q, active_d;
  logic [VOICES-1:0]         start_q, start_d;
  logic                      load;
  logic                      any_busy_d;

  // new_note is ignored while paused.
  assign load = bus.new_note & bus.play;

  always_comb begin
    any_busy_d = 1'b0;
    start_d    = '0;
    active_d   = active_q;
    for (int unsigned v = 0; v < VOICES; v++) begin
      note_d[v]      = note_q[v];
      remaining_d[v] = remaining_q[v];
      if (load) begin
        // Load wins over a coincident beat: the fresh duration is not decremented.
        note_d[v]      = bus.notes_in[(VOICES-1-v)*NOTE_WIDTH +: NOTE_WIDTH];
        remaining_d[v] = bus.durations_in[(VOICES-1-v)*DURATION_WIDTH +: DURATION_WIDTH];
        active_d[v]    = (remaining_d[v] != '0) && (note_d[v] != '0);
        start_d[v]     = active_d[v];
      end else if (bus.beat && bus.play && (remaining_q[v] != '0)) begin
        remaining_d[v] = remaining_q[v] - DURATION_WIDTH'(1);
        if (remaining_q[v] == DURATION_WIDTH'(1)) begin
          active_d[v] = 1'b0;
        end
      end
      // A rest with nonzero duration keeps the chord busy without being active.
      if (remaining_d[v] != '0) begin
        any_busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned v = 0; v < VOICES; v++) begin
        note_q[v]      <= '0;
        remaining_q[v] <= '0;
      end
      active_q <= '0;
      start_q  <= '0;
      state_q  <= StIdle;
    end else begin
      for (int unsigned v = 0; v < VOICES; v++) begin
        note_q[v]      <= note_d[v];
        remaining_q[v] <= remaining_d[v];
      end
      active_q <= active_d;
      start_q  <= start_d;
      state_q  <= state_d;
    end
  end

  // A load always re-decides the state from the new chord, so a retrigger
  // never reports completion of the abandoned chord.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (load) state_d = any_busy_d ? StPlaying : StDone;
      end
      StPlaying: begin
        if (!any_busy_d) state_d = StDone;
      end
      StDone: begin
        if (load) state_d = any_busy_d ? StPlaying : StDone;
        else      state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.voice_note   = '0;
    bus.voice_active = '0;
    bus.voice_start  = '0;
    for (int unsigned v = 0; v < VOICES; v++) begin
      bus.voice_note[(VOICES-1-v)*NOTE_WIDTH +: NOTE_WIDTH] =
          (bus.play && active_q[v]) ? note_q[v] : '0;
      bus.voice_active[VOICES-1-v] = active_q[v];
      bus.voice_start[VOICES-1-v]  = start_q[v];
    end
  end

  assign bus.note_done = (state_q == StDone);

endmodule
